// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between the fetch and data requesters,
// data first, with a streak counter that bounds how long fetch can be starved.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_rd,
    output logic          m_wr,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_done,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_q, wr_d, err_q, err_d;
    logic [3:0]    streak_q, streak_d;
    logic          idle, grant_d, grant_i;
    always_comb begin
        idle     = state_q == IDLE;
        grant_d  = idle && (d_rd || d_wr) && !(i_req && streak_q == 4'(STARVE_MAX));
        grant_i  = idle && !grant_d && i_req;
        state_d  = grant_d ? BUSY_D : grant_i ? BUSY_I : (!idle && m_done) ? IDLE : state_q;
        addr_d   = grant_d ? d_addr : grant_i ? i_addr : addr_q;
        wdata_d  = grant_d ? d_wdata : wdata_q;
        wr_d     = grant_d ? d_wr : wr_q;
        err_d    = err_q || (idle && d_rd && d_wr);
        // Only data grants won while fetch waits extend the streak
        streak_d = !idle ? streak_q : (grant_i || !i_req) ? 4'd0 :
                   (streak_q != 4'(STARVE_MAX)) ? streak_q + 4'd1 : streak_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            streak_q <= streak_d;
        end
    end
    assign busy    = state_q != IDLE;
    assign m_rd    = state_q == BUSY_I || (state_q == BUSY_D && !wr_q);
    assign m_wr    = state_q == BUSY_D && wr_q;
    assign m_addr  = busy ? addr_q : '0;
    assign m_wdata = state_q == BUSY_D ? wdata_q : '0;
    assign i_done  = state_q == BUSY_I && m_done;
    assign d_done  = state_q == BUSY_D && m_done;
    assign i_rdata = i_done ? m_rdata : '0;
    assign d_rdata = d_done ? m_rdata : '0;
    assign err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int STARVE = 4;
    logic        clk = 0, rst = 0;
    logic        i_req = 0, d_rd = 0, d_wr = 0, m_done = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_done, d_done, m_rd, m_wr, busy, err;
    int          vecs = 0, errs = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr), .m_rdata(m_rdata), .m_done(m_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: owner 0 none, 1 fetch, 2 data
    int          mst = 0, streak = 0;
    logic [15:0] ma = 0, mw = 0;
    logic        mwr = 0, merr = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mst <= 0; streak <= 0; ma <= 0; mw <= 0; mwr <= 0; merr <= 0;
        end else if (mst == 0) begin
            if (d_rd && d_wr) merr <= 1;
            if ((d_rd || d_wr) && !(i_req && streak == STARVE)) begin
                mst <= 2; ma <= d_addr; mw <= d_wdata; mwr <= d_wr;
                streak <= i_req ? ((streak + 1 > STARVE) ? STARVE : streak + 1) : 0;
            end else if (i_req) begin
                mst <= 1; ma <= i_addr; streak <= 0;
            end else streak <= 0;
        end else if (m_done) mst <= 0;
    end

    logic [69:0] e_v, a_v;
    always @(negedge clk) begin
        e_v = {mst != 0 ? ma : 16'h0, mst == 2 ? mw : 16'h0, mst == 1 || (mst == 2 && !mwr),
               mst == 2 && mwr, mst != 0, merr, mst == 1 && m_done, (mst == 1 && m_done) ? m_rdata : 16'h0,
               mst == 2 && m_done, (mst == 2 && m_done) ? m_rdata : 16'h0};
        a_v = {m_addr, m_wdata, m_rd, m_wr, busy, err, i_done, i_rdata, d_done, d_rdata};
        chk("cycle", a_v, e_v);
    end

    logic idn, ddn;
    int   r;
    initial begin
        i_req = 1; i_addr = 16'h0040;
        tick;
        chk("reset_outs", {m_rd, m_wr, busy, err, i_done, d_done, m_addr}, 0);
        rst = 1;
        tick;
        chk("fetch_issue", {m_rd, m_wr, busy, m_addr}, {3'b101, 16'h0040});
        m_done = 1; m_rdata = 16'h1234; #1;
        chk("fetch_done", {i_done, i_rdata, d_done}, {1'b1, 16'h1234, 1'b0});
        tick;
        i_req = 0; m_done = 0;
        chk("idle_bubble", {busy, m_rd}, 0);
        i_req = 1; i_addr = 16'h0080; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        tick;
        chk("contend_d", {m_wr, m_rd, m_addr, m_wdata}, {2'b10, 16'h0100, 16'hBEEF});
        m_done = 1; #1;
        chk("contend_ddone", {d_done, i_done}, 2'b10);
        tick;
        d_wr = 0; m_done = 0;
        tick;
        chk("contend_i", {m_rd, m_addr}, {1'b1, 16'h0080});
        m_done = 1;
        tick;
        i_req = 0; m_done = 0;
        i_req = 1; i_addr = 16'h0200; d_rd = 1;
        for (int n = 0; n < 10; n++) begin
            d_addr = 16'h0010 + 16'(n);
            tick;
            chk("starve_grant", {m_rd, m_addr == 16'h0200}, {1'b1, n % 5 == 4});
            m_done = 1;
            tick;
            m_done = 0;
        end
        i_req = 0; d_rd = 0;
        tick;
        i_req = 1; i_addr = 16'h0300;
        tick;
        for (int j = 0; j < 5; j++) begin
            chk("lat_hold", {m_rd, busy, i_done, m_addr}, {3'b110, 16'h0300});
            tick;
        end
        m_done = 1; m_rdata = 16'h0BAD; i_req = 0; #1;
        chk("lat_done", {m_rd, i_done, i_rdata}, {2'b11, 16'h0BAD});
        tick;
        m_done = 0;
        chk("lat_nogrant", {busy, m_rd}, 0);
        d_wr = 1; d_addr = 16'h0400; d_wdata = 16'h0005;
        tick;
        chk("ar_issue", {m_wr, busy}, 2'b11);
        #2; m_done = 1; rst = 0; #1;
        chk("ar_drop", {m_wr, busy, d_done}, 0);
        tick;
        rst = 1; m_done = 0;
        tick;
        chk("ar_fresh", {m_wr, busy, m_addr}, {2'b11, 16'h0400});
        m_done = 1;
        tick;
        d_wr = 0; m_done = 0;
        d_rd = 1; d_wr = 1; d_addr = 16'h0500; #1;
        chk("err_pre", err, 0);
        tick;
        chk("err_set", {err, m_wr, m_rd, m_addr}, {3'b110, 16'h0500});
        m_done = 1;
        tick;
        d_rd = 0; d_wr = 0; m_done = 0;
        tick;
        chk("err_sticky", err, 1);
        rst = 0; #1;
        chk("err_clear", err, 0);
        tick;
        rst = 1;
        for (int c = 0; c < 3000; c++) begin
            m_done = ($urandom % 3) == 0; m_rdata = 16'($urandom);
            #2;
            idn = i_done; ddn = d_done;
            if ($urandom % 250 == 0) begin
                rst = 0; #1;
                chk("rand_rst", {m_rd, m_wr, busy, i_done, d_done, err}, 0);
            end
            tick;
            rst = 1;
            if (idn || !i_req) begin
                i_req = ($urandom % 3) == 0; i_addr = 16'($urandom);
            end
            if (ddn || !(d_rd || d_wr)) begin
                r = $urandom % 40;
                d_rd = r < 8 || r == 39; d_wr = (r >= 8 && r < 14) || r == 39;
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
